// File: rtl/rr_bus_mux.sv
// Registered N-to-1 bus multiplexer with fixed-priority / round-robin arbitration,
// optional bus lock, and a one-deep valid/ready output stage.
module rr_bus_mux #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned CHANNELS = 4,
  localparam int unsigned SRCW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic [CHANNELS-1:0]       Req,
  input  logic [CHANNELS*WIDTH-1:0] Data_in,
  input  logic                      Mode,
  input  logic                      Lock,
  output logic [CHANNELS-1:0]       Grant,
  output logic [WIDTH-1:0]          Out,
  output logic [SRCW-1:0]           Out_src,
  output logic                      Out_valid,
  input  logic                      Out_ready
);

  logic [SRCW-1:0] last_q;
  logic [SRCW-1:0] winner;
  logic            found;
  logic            free;
  logic            accept;
  int              idx;

  assign free   = !Out_valid || Out_ready;
  assign accept = free && (|Req) && !Reset;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    if (Lock && Req[last_q]) begin
      winner = last_q;
      found  = 1'b1;
    end else if (!Mode) begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        if (!found && Req[i]) begin
          winner = SRCW'(i);
          found  = 1'b1;
        end
      end
    end else begin
      // Search starts just after the previous winner and wraps around.
      for (int k = 1; k <= int'(CHANNELS); k++) begin
        idx = (int'(last_q) + k) % int'(CHANNELS);
        if (!found && Req[idx]) begin
          winner = SRCW'(idx);
          found  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    Grant = '0;
    if (accept) Grant[winner] = 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      Out       <= '0;
      Out_src   <= '0;
      Out_valid <= 1'b0;
      last_q    <= SRCW'(CHANNELS - 1);
    end else if (accept) begin
      Out       <= Data_in[winner*WIDTH +: WIDTH];
      Out_src   <= winner;
      Out_valid <= 1'b1;
      last_q    <= winner;
    end else if (Out_ready) begin
      Out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_bus_mux.sv
// Directed bench for rr_bus_mux: expected words are queued at grant time and
// checked against the output register one cycle later.
module tb_rr_bus_mux;
  localparam int W = 16;
  localparam int N = 4;

  logic           Clk = 1'b0;
  logic           Reset;
  logic [N-1:0]   Req;
  logic [N*W-1:0] Data_in;
  logic           Mode;
  logic           Lock;
  logic [N-1:0]   Grant;
  logic [W-1:0]   Out;
  logic [1:0]     Out_src;
  logic           Out_valid;
  logic           Out_ready;

  logic [W-1:0] dat [N];
  assign Data_in = {dat[3], dat[2], dat[1], dat[0]};

  always #5 Clk = ~Clk;

  rr_bus_mux #(.WIDTH(W), .CHANNELS(N)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .Data_in(Data_in), .Mode(Mode), .Lock(Lock),
    .Grant(Grant), .Out(Out), .Out_src(Out_src), .Out_valid(Out_valid), .Out_ready(Out_ready)
  );

  typedef struct packed {
    logic [W-1:0] d;
    logic [1:0]   s;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check the combinational grant, queue the expected word, clock once, then
  // compare the output register against the oldest queued word.
  task automatic cyc(input string tag, input logic [N-1:0] exp_g);
    exp_t e;
    #1;
    chk({tag, " grant"}, 32'(Grant), 32'(exp_g));
    for (int i = 0; i < N; i++) begin
      if (exp_g[i]) begin
        e.d = dat[i];
        e.s = 2'(i);
        sb.push_back(e);
      end
    end
    @(posedge Clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, " out"}, 32'(Out), 32'(e.d));
      chk({tag, " src"}, 32'(Out_src), 32'(e.s));
      chk({tag, " valid"}, 32'(Out_valid), 32'd1);
    end
  endtask

  task automatic chk_state(input string tag, input logic v, input logic [W-1:0] o,
                           input logic [1:0] s);
    chk({tag, " valid"}, 32'(Out_valid), 32'(v));
    chk({tag, " out"}, 32'(Out), 32'(o));
    chk({tag, " src"}, 32'(Out_src), 32'(s));
  endtask

  initial begin
    dat[0] = 16'hA; dat[1] = 16'hB; dat[2] = 16'hC; dat[3] = 16'hD;
    Reset = 1'b1; Req = 4'b1111; Mode = 1'b0; Lock = 1'b0; Out_ready = 1'b1;

    // 1: reset, then channel 0 wins first
    cyc("rst0", 4'b0000);
    chk_state("rst0", 1'b0, 16'h0, 2'd0);
    cyc("rst1", 4'b0000);
    chk_state("rst1", 1'b0, 16'h0, 2'd0);
    Reset = 1'b0;
    cyc("t1", 4'b0001);

    // 2: round-robin rotation without bubbles
    Mode = 1'b1;
    cyc("rr1", 4'b0010);
    cyc("rr2", 4'b0100);
    cyc("rr3", 4'b1000);
    cyc("rr0", 4'b0001);

    // 3: fixed priority starves channel 3 until alone
    Mode = 1'b0; Req = 4'b1010;
    cyc("fp_a", 4'b0010);
    cyc("fp_b", 4'b0010);
    cyc("fp_c", 4'b0010);
    Req = 4'b1000;
    cyc("fp_3", 4'b1000);

    // 4: stall holds output and blocks grants, release refills same cycle
    Req = 4'b0100;
    cyc("st_acc", 4'b0100);
    Out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc("stall", 4'b0000);
      chk_state("stall", 1'b1, 16'hC, 2'd2);
    end
    dat[2] = 16'hCC;
    Out_ready = 1'b1;
    cyc("st_rel", 4'b0100);

    // drain without refill keeps data and source
    Req = 4'b0000;
    cyc("drain", 4'b0000);
    chk_state("drain", 1'b0, 16'hCC, 2'd2);

    // 5: lock keeps channel 2, then round-robin wraps to 0
    Mode = 1'b1; Lock = 1'b1; Req = 4'b0100;
    cyc("lk_w", 4'b0100);
    Req = 4'b0111;
    cyc("lk_a", 4'b0100);
    cyc("lk_b", 4'b0100);
    cyc("lk_c", 4'b0100);
    Req = 4'b0011;
    cyc("lk_drop", 4'b0001);
    Lock = 1'b0;

    // 6: reset while a word is stalled discards it
    Mode = 1'b0; Req = 4'b0100;
    cyc("r6_acc", 4'b0100);
    Out_ready = 1'b0;
    cyc("r6_stall", 4'b0000);
    chk_state("r6_stall", 1'b1, 16'hCC, 2'd2);
    Reset = 1'b1;
    cyc("r6_rst", 4'b0000);
    chk_state("r6_rst", 1'b0, 16'h0, 2'd0);
    Reset = 1'b0; Mode = 1'b1; Req = 4'b1111; Out_ready = 1'b1;
    cyc("r6_first", 4'b0001);
    chk("sb empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
